axis_peak_collect: RTL and testbench

//   Drains the NUM_TAGS per-tag peak-burst AXIS streams from the peak detector bank into one AXIS stream.

---
 rtl/axis_peak_collect_if.sv | 16 +
 rtl/axis_peak_collect.sv | 176 +++++++++++++++++
 tb/tb_axis_peak_collect.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_peak_collect_if.sv
// AXI-stream bundle: LANES parallel valid/ready/last lanes sharing one packed data bus.
// Lane i owns tdata[i*DATA_W +: DATA_W]; the master drives tuser for the whole bundle.
interface axis_peak_collect_if #(
    parameter int LANES  = 1,
    parameter int DATA_W = 256,
    parameter int USER_W = 5
);
    logic [LANES-1:0]        tvalid;
    logic [LANES-1:0]        tready;
    logic [LANES-1:0]        tlast;
    logic [LANES*DATA_W-1:0] tdata;
    logic [USER_W-1:0]       tuser;

    modport master (output tvalid, tdata, tlast, tuser, input tready);
    modport slave  (input tvalid, tdata, tlast, tuser, output tready);
endinterface

// File: rtl/axis_peak_collect.sv
// Collects per-tag peak bursts into one tagged AXIS stream, round-robin per whole burst.
// Latency: 1 cycle input accept to m_axis.tvalid; 1 arbitration cycle between bursts.
// Backpressure: granted tag's tready follows the output register (empty or draining).
module axis_peak_collect #(
    parameter int NUM_TAGS      = 20,
    parameter int BURST_LENGTH  = 32,
    parameter int CHANNEL_WIDTH = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    axis_peak_collect_if.slave  s_axis,
    axis_peak_collect_if.master m_axis,
    output logic [15:0]         err_count
);
    localparam int DATA_WIDTH = 4 * CHANNEL_WIDTH;
    localparam int TAG_WIDTH  = $clog2(NUM_TAGS);
    localparam int CNT_WIDTH  = $clog2(BURST_LENGTH) + 1;
    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BURST_LENGTH - 1);
    localparam logic [TAG_WIDTH-1:0] LAST_TAG  = TAG_WIDTH'(NUM_TAGS - 1);

    typedef enum logic [1:0] {IDLE, XFER, DROP} state_t;

    state_t                 state_q, state_d;
    logic [TAG_WIDTH-1:0]   grant_q, grant_d;
    logic [TAG_WIDTH-1:0]   last_q, last_d;
    logic [CNT_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;
    logic                   m_vld_q, m_vld_d;
    logic                   m_lst_q, m_lst_d;
    logic [DATA_WIDTH-1:0]  m_dat_q, m_dat_d;
    logic [TAG_WIDTH-1:0]   m_usr_q, m_usr_d;
    logic [15:0]            err_q, err_d;

    logic                   arb_vld;
    logic [TAG_WIDTH-1:0]   arb_idx;
    logic                   sel_vld, sel_lst, sel_rdy;
    logic [DATA_WIDTH-1:0]  sel_dat;
    logic [NUM_TAGS-1:0]    s_rdy;
    logic                   accept, load, last_beat;
    logic [15:0]            err_inc;

    // Search order last+1, last+2, ... wrapping at NUM_TAGS; first requester wins.
    always_comb begin
        int                   idx;
        logic [TAG_WIDTH-1:0] idx_t;
        arb_vld = 1'b0;
        arb_idx = '0;
        idx     = 0;
        idx_t   = '0;
        for (int k = 1; k <= NUM_TAGS; k++) begin
            idx = int'(last_q) + k;
            if (idx >= NUM_TAGS) begin
                idx = idx - NUM_TAGS;
            end
            idx_t = TAG_WIDTH'(idx);
            if (!arb_vld && s_axis.tvalid[idx_t]) begin
                arb_vld = 1'b1;
                arb_idx = idx_t;
            end
        end
    end

    always_comb begin
        sel_rdy = 1'b0;
        if (state_q == XFER) begin
            sel_rdy = !m_vld_q || m_axis.tready[0];
        end else if (state_q == DROP) begin
            sel_rdy = 1'b1;
        end
    end

    always_comb begin
        sel_vld = 1'b0;
        sel_lst = 1'b0;
        sel_dat = '0;
        s_rdy   = '0;
        for (int t = 0; t < NUM_TAGS; t++) begin
            if (grant_q == TAG_WIDTH'(t)) begin
                sel_vld  = s_axis.tvalid[t];
                sel_lst  = s_axis.tlast[t];
                sel_dat  = s_axis.tdata[t*DATA_WIDTH +: DATA_WIDTH];
                s_rdy[t] = sel_rdy;
            end
        end
    end

    assign accept    = sel_vld && sel_rdy;
    assign load      = accept && (state_q == XFER);
    assign last_beat = (beat_cnt_q == LAST_BEAT);
    assign err_inc   = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;
        m_vld_d    = m_vld_q;
        m_lst_d    = m_lst_q;
        m_dat_d    = m_dat_q;
        m_usr_d    = m_usr_q;

        // A load in the same cycle as a downstream accept simply replaces the beat.
        if (load) begin
            m_vld_d = 1'b1;
            m_dat_d = sel_dat;
            m_usr_d = grant_q;
            m_lst_d = sel_lst || last_beat;
        end else if (m_axis.tready[0]) begin
            m_vld_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    grant_d    = arb_idx;
                    beat_cnt_d = '0;
                    state_d    = XFER;
                end
            end
            XFER: begin
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (sel_lst) begin
                        if (!last_beat) begin
                            err_d = err_inc;
                        end
                        last_d  = grant_q;
                        state_d = IDLE;
                    end else if (last_beat) begin
                        // Overlong burst: the forced tlast is already in the load above.
                        err_d   = err_inc;
                        state_d = DROP;
                    end
                end
            end
            DROP: begin
                if (accept && sel_lst) begin
                    last_d  = grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            last_q     <= LAST_TAG;
            beat_cnt_q <= '0;
            err_q      <= '0;
            m_vld_q    <= 1'b0;
            m_lst_q    <= 1'b0;
            m_dat_q    <= '0;
            m_usr_q    <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
            m_vld_q    <= m_vld_d;
            m_lst_q    <= m_lst_d;
            m_dat_q    <= m_dat_d;
            m_usr_q    <= m_usr_d;
        end
    end

    assign s_axis.tready = s_rdy;
    assign m_axis.tvalid = m_vld_q;
    assign m_axis.tlast  = m_lst_q;
    assign m_axis.tdata  = m_dat_q;
    assign m_axis.tuser  = m_usr_q;
    assign err_count     = err_q;
endmodule

// File: tb/tb_axis_peak_collect.sv
// Directed bench for axis_peak_collect: per-tag burst sources, output monitor, assertion checks.
module tb_axis_peak_collect;
    localparam int NT = 20;
    localparam int BL = 32;
    localparam int CW = 64;
    localparam int DW = 4 * CW;
    localparam int TW = 5;

    typedef struct {
        logic [TW-1:0] user;
        logic          lst;
        logic [DW-1:0] dat;
        int            cyc;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] err_count;

    axis_peak_collect_if #(.LANES(NT), .DATA_W(DW), .USER_W(TW)) s_if ();
    axis_peak_collect_if #(.LANES(1),  .DATA_W(DW), .USER_W(TW)) m_if ();

    axis_peak_collect #(.NUM_TAGS(NT), .BURST_LENGTH(BL), .CHANNEL_WIDTH(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_axis    (s_if),
        .m_axis    (m_if),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int    req [NT];
    int    done [NT];
    int    sent [NT];
    int    blen [NT];
    int    lpos [NT];
    bit    act [NT];
    bit    rnd_rdy;
    int    n_assert;
    int    n_fail;
    int    cyc;
    beat_t obs_q [$];

    function automatic logic [DW-1:0] mk_dat(input int t, input int b);
        logic [31:0] w;
        w = {t[15:0], b[15:0]};
        return {8{w}};
    endfunction

    task automatic chk(input string name, input logic [299:0] obs, input logic [299:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Sources: each tag plays its requested bursts back to back, advancing on handshakes.
    initial begin
        logic [NT-1:0] acc;
        s_if.tvalid = '0;
        s_if.tlast  = '0;
        s_if.tdata  = '0;
        s_if.tuser  = '0;
        m_if.tready = 1'b1;
        for (int t = 0; t < NT; t++) begin
            done[t] = 0;
            sent[t] = 0;
            act[t]  = 1'b0;
        end
        forever begin
            @(negedge clk);
            acc = s_if.tvalid & s_if.tready;
            @(posedge clk);
            #1;
            for (int t = 0; t < NT; t++) begin
                if (!rst_n) begin
                    act[t]  = 1'b0;
                    done[t] = req[t];
                end else begin
                    if (acc[t] && act[t]) begin
                        sent[t]++;
                        if (sent[t] == blen[t]) begin
                            act[t] = 1'b0;
                            done[t]++;
                        end
                    end
                    if (!act[t] && done[t] != req[t]) begin
                        act[t]  = 1'b1;
                        sent[t] = 0;
                    end
                end
                s_if.tvalid[t] = act[t];
                s_if.tlast[t]  = act[t] && (sent[t] + 1 == lpos[t]);
                s_if.tdata[t*DW +: DW] = act[t] ? mk_dat(t, sent[t]) : '0;
            end
            m_if.tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: records accepted output beats, checks hold-while-stalled and one-hot ready.
    initial begin
        beat_t        b;
        logic         stall_p;
        logic [299:0] held;
        cyc     = 0;
        stall_p = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                chk("tready_onehot0", 300'($onehot0(s_if.tready)), 300'(1));
                if (stall_p) begin
                    chk("stall_hold", 300'({m_if.tvalid, m_if.tuser, m_if.tlast, m_if.tdata}), held);
                end
                if (m_if.tvalid[0] && m_if.tready[0]) begin
                    b.user = m_if.tuser;
                    b.lst  = m_if.tlast[0];
                    b.dat  = m_if.tdata;
                    b.cyc  = cyc;
                    obs_q.push_back(b);
                end
                stall_p = m_if.tvalid[0] && !m_if.tready[0];
                held    = 300'({m_if.tvalid, m_if.tuser, m_if.tlast, m_if.tdata});
            end else begin
                stall_p = 1'b0;
            end
        end
    end

    task automatic wait_done(input int budget);
        int n;
        bit all;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            all = 1'b1;
            for (int t = 0; t < NT; t++) begin
                if (done[t] != req[t]) all = 1'b0;
            end
        end while (!all && n < budget);
        chk("drain_timeout", 300'(all), 300'(1));
        rnd_rdy = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_burst(input int tag, input int n, output int fc, output int lc);
        beat_t b;
        fc = -1;
        lc = -1;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("beat_present t%0d b%0d", tag, i), 300'(obs_q.size() > 0), 300'(1));
            if (obs_q.size() == 0) return;
            b = obs_q.pop_front();
            chk($sformatf("beat t%0d b%0d", tag, i), 300'({b.user, b.lst, b.dat}),
                300'({TW'(tag), 1'(i == n - 1), mk_dat(tag, i)}));
            if (i == 0) fc = b.cyc;
            lc = b.cyc;
        end
    endtask

    initial begin
        int  f0, l0, f1, l1, n;
        bit  any_lst, all_t9;
        beat_t b;
        n_assert = 0;
        n_fail   = 0;
        rnd_rdy  = 1'b0;
        for (int t = 0; t < NT; t++) begin
            req[t]  = 0;
            blen[t] = BL;
            lpos[t] = BL;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_m_tvalid", 300'(m_if.tvalid), 300'(0));
        chk("rst_m_tlast",  300'(m_if.tlast), 300'(0));
        chk("rst_m_tdata",  300'(m_if.tdata), 300'(0));
        chk("rst_m_tuser",  300'(m_if.tuser), 300'(0));
        chk("rst_s_tready", 300'(s_if.tready), 300'(0));
        chk("rst_err",      300'(err_count), 300'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // All tags request at once: tag 0 first, every tag once, then tag 0 again.
        for (int t = 0; t < NT; t++) req[t]++;
        req[0]++;
        wait_done(1200);
        for (int k = 0; k <= NT; k++) check_burst(k % NT, BL, f0, l0);
        chk("rr_err", 300'(err_count), 300'(0));

        // Tags 3 and 7 together: back-to-back bursts with one arbitration cycle between.
        req[3]++;
        req[7]++;
        wait_done(200);
        check_burst(3, BL, f0, l0);
        check_burst(7, BL, f1, l1);
        chk("t3_contiguous", 300'(l0 - f0), 300'(BL - 1));
        chk("idle_gap", 300'(f1 - l0), 300'(2));
        chk("t1_err", 300'(err_count), 300'(0));

        // Random downstream backpressure.
        rnd_rdy = 1'b1;
        req[12]++;
        wait_done(600);
        check_burst(12, BL, f0, l0);
        chk("bp_queue_empty", 300'(obs_q.size()), 300'(0));

        // Overlong burst from tag 5; tags 4 and 6 queue up behind it.
        blen[5] = 40;
        lpos[5] = 40;
        req[5]++;
        repeat (5) @(negedge clk);
        req[4]++;
        req[6]++;
        wait_done(400);
        check_burst(5, BL, f0, l0);
        check_burst(6, BL, f0, l0);
        check_burst(4, BL, f0, l0);
        chk("long_err", 300'(err_count), 300'(1));
        chk("long_queue_empty", 300'(obs_q.size()), 300'(0));
        blen[5] = BL;
        lpos[5] = BL;

        // Short burst from tag 2, then a normal burst proves the arbiter is free again.
        blen[2] = 10;
        lpos[2] = 10;
        req[2]++;
        wait_done(100);
        check_burst(2, 10, f0, l0);
        chk("short_err", 300'(err_count), 300'(2));
        req[1]++;
        wait_done(100);
        check_burst(1, BL, f0, l0);
        chk("short_err_hold", 300'(err_count), 300'(2));

        // Reset in the middle of a tag 9 burst.
        req[9]++;
        n = 0;
        while (obs_q.size() < 15 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("reach_beat15", 300'(obs_q.size() >= 15), 300'(1));
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_m_tvalid", 300'(m_if.tvalid), 300'(0));
        chk("mid_rst_s_tready", 300'(s_if.tready), 300'(0));
        chk("mid_rst_err",      300'(err_count), 300'(0));
        chk("mid_rst_m_tlast",  300'(m_if.tlast), 300'(0));
        any_lst = 1'b0;
        all_t9  = 1'b1;
        while (obs_q.size() > 0) begin
            b = obs_q.pop_front();
            if (b.lst) any_lst = 1'b1;
            if (b.user != TW'(9)) all_t9 = 1'b0;
        end
        chk("aborted_no_tlast", 300'(any_lst), 300'(0));
        chk("aborted_tag", 300'(all_t9), 300'(1));
        rst_n = 1'b1;
        req[1]++;
        req[0]++;
        wait_done(200);
        check_burst(0, BL, f0, l0);
        check_burst(1, BL, f1, l1);
        chk("post_rst_err", 300'(err_count), 300'(0));
        chk("final_queue_empty", 300'(obs_q.size()), 300'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
